// File: rtl/sha_pkg.sv
// Shared types, round constants and small-sigma helpers for the SHA-256 message schedule.
// Optional feature macro used by the block: SHA_WSCHED_KW_EN (adds kw_out = k_out + w_out).
package sha_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WIN_N   = 16;
  localparam int unsigned BLK_W   = 512;
  localparam int unsigned ROUND_W = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam word_t SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t sha_s0_small(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sha_s1_small(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_wsched_if.sv
// Block-in / word-out handshake bundle of the message-schedule source.
// kw_out exists only when SHA_WSCHED_KW_EN is defined.
interface sha_wsched_if;
  import sha_pkg::*;

  logic                 blk_valid;
  logic                 blk_ready;
  logic [BLK_W-1:0]     blk_data;
  logic                 w_valid;
  logic                 w_ready;
  word_t                w_out;
  word_t                k_out;
  logic [ROUND_W-1:0]   round;
  logic                 last;
`ifdef SHA_WSCHED_KW_EN
  word_t                kw_out;
`endif

  modport master (
    output blk_valid, blk_data, w_ready,
    input  blk_ready, w_valid, w_out, k_out, round, last
`ifdef SHA_WSCHED_KW_EN
    , input kw_out
`endif
  );

  modport slave (
    input  blk_valid, blk_data, w_ready,
    output blk_ready, w_valid, w_out, k_out, round, last
`ifdef SHA_WSCHED_KW_EN
    , output kw_out
`endif
  );

endinterface

// File: rtl/sha_wexpand.sv
// Combinational next-schedule word from the 16-word sliding window taps.
module sha_wexpand
  import sha_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t w_next_c
);

  // window[1] is W[t-15] and window[14] is W[t-2] relative to the new word.
  assign w_next_c = sha_s1_small(w14) + w9 + sha_s0_small(w1) + w0;

endmodule

// File: rtl/sha_wsched.sv
// SHA-256 message-schedule source: takes one padded block, streams W[t]/K[t] for t=0..ROUNDS-1.
// Define SHA_WSCHED_KW_EN to add the registered kw_out = k_out + w_out output.
module sha_wsched
  import sha_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  sha_wsched_if.slave  bus
);

  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_RUN  = 1'(RUN);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  logic [0:0]         state_q,     state_d;
  word_t              window_q [WIN_N];
  word_t              window_d [WIN_N];
  logic [ROUND_W-1:0] round_q,     round_d;
  word_t              k_out_q,     k_out_d;
  logic               blk_ready_q, blk_ready_d;
  logic               w_valid_q,   w_valid_d;
  logic               last_q,      last_d;
  word_t              w_next;
  logic               blk_fire;
  logic               w_fire;

  sha_wexpand u_wexpand (
    .w0       (window_q[0]),
    .w1       (window_q[1]),
    .w9       (window_q[9]),
    .w14      (window_q[14]),
    .w_next_c (w_next)
  );

  assign blk_fire = blk_ready_q && bus.blk_valid;
  assign w_fire   = w_valid_q && bus.w_ready;

  // Next-state, window and round update; outputs are derived from the next state.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    round_d  = round_q;

    case (state_q)
      S_IDLE: begin
        if (blk_fire) begin
          state_d = S_RUN;
          round_d = '0;
          for (int i = 0; i < int'(WIN_N); i++) begin
            window_d[i] = bus.blk_data[BLK_W-1-(WORD_W*i) -: WORD_W];
          end
        end
      end
      S_RUN: begin
        if (w_fire) begin
          for (int i = 0; i < int'(WIN_N) - 1; i++) begin
            window_d[i] = window_q[i+1];
          end
          window_d[WIN_N-1] = w_next;
          if (last_q) begin
            state_d = S_IDLE;
            round_d = '0;
          end else begin
            round_d = ROUND_W'(round_q + ROUND_W'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    blk_ready_d = (state_d == S_IDLE);
    w_valid_d   = (state_d == S_RUN);
    last_d      = (state_d == S_RUN) && (round_d == LAST_ROUND);
    k_out_d     = SHA_K[round_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      k_out_q     <= SHA_K[0];
      blk_ready_q <= 1'b1;
      w_valid_q   <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        window_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      k_out_q     <= k_out_d;
      blk_ready_q <= blk_ready_d;
      w_valid_q   <= w_valid_d;
      last_q      <= last_d;
      window_q    <= window_d;
    end
  end

`ifdef SHA_WSCHED_KW_EN
  word_t kw_out_q, kw_out_d;

  // Pre-summed K+W so the round adder needs one operand fewer.
  always_comb begin
    kw_out_d = k_out_d + window_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kw_out_q <= SHA_K[0];
    end else begin
      kw_out_q <= kw_out_d;
    end
  end

  assign bus.kw_out = kw_out_q;
`endif

  assign bus.blk_ready = blk_ready_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_out     = window_q[0];
  assign bus.k_out     = k_out_q;
  assign bus.round     = round_q;
  assign bus.last      = last_q;

endmodule
